// File: rtl/dtree_seq_classifier.sv
// Sequential decision-tree classifier: walks a writable node table one node per cycle.
// Optional macro DTREE_PREC_MASK_EN adds a per-node compare-precision field (prec MSBs only).
module dtree_seq_classifier #(
  parameter int unsigned NUM_FEAT  = 16,
  parameter int unsigned FEAT_W    = 8,
  parameter int unsigned CLASS_W   = 4,
  parameter int unsigned NUM_NODES = 64,
  parameter int unsigned MAX_STEPS = 15,
  localparam int unsigned NODE_AW  = $clog2(NUM_NODES),
  localparam int unsigned FIDX_W   = $clog2(NUM_FEAT),
`ifdef DTREE_PREC_MASK_EN
  localparam int unsigned PREC_W   = $clog2(FEAT_W) + 1,
`else
  localparam int unsigned PREC_W   = 0,
`endif
  localparam int unsigned NODE_W   = PREC_W + 1 + FIDX_W + FEAT_W + 2 * NODE_AW + CLASS_W
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [NUM_FEAT*FEAT_W-1:0] in_feat,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [CLASS_W-1:0]         out_class,
  output logic                       out_err,
  input  logic                       cfg_we,
  input  logic [NODE_AW-1:0]         cfg_addr,
  input  logic [NODE_W-1:0]          cfg_wdata
);

  localparam int unsigned STEP_W    = $clog2(MAX_STEPS + 1);
  localparam int unsigned RIGHT_LSB = CLASS_W;
  localparam int unsigned LEFT_LSB  = RIGHT_LSB + NODE_AW;
  localparam int unsigned THR_LSB   = LEFT_LSB + NODE_AW;
  localparam int unsigned FIDX_LSB  = THR_LSB + FEAT_W;
  localparam int unsigned LEAF_BIT  = FIDX_LSB + FIDX_W;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WALK = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                     r_state, w_state_nxt;
  logic [NUM_FEAT*FEAT_W-1:0] r_feat, w_feat_nxt;
  logic [NODE_AW-1:0]         r_ptr, w_ptr_nxt;
  logic [STEP_W-1:0]          r_steps, w_steps_nxt;
  logic                       r_in_ready, w_in_ready_nxt;
  logic                       r_out_valid, w_out_valid_nxt;
  logic [CLASS_W-1:0]         r_out_class, w_out_class_nxt;
  logic                       r_out_err, w_out_err_nxt;
  logic                       w_mem_we;

  // Node table: not reset, written only while idle
  logic [NODE_W-1:0] r_mem [NUM_NODES];

  always_ff @(posedge clk) begin
    if (w_mem_we) begin
      r_mem[cfg_addr] <= cfg_wdata;
    end
  end

  // Current node decode; pointers beyond the table read as an all-zero entry
  logic [NODE_W-1:0]  w_node;
  logic               w_is_leaf;
  logic [FIDX_W-1:0]  w_fidx;
  logic [FEAT_W-1:0]  w_thr;
  logic [NODE_AW-1:0] w_left;
  logic [NODE_AW-1:0] w_right;
  logic [CLASS_W-1:0] w_cls;

  assign w_node    = (32'(r_ptr) < NUM_NODES) ? r_mem[r_ptr] : '0;
  assign w_is_leaf = w_node[LEAF_BIT];
  assign w_fidx    = w_node[FIDX_LSB +: FIDX_W];
  assign w_thr     = w_node[THR_LSB +: FEAT_W];
  assign w_left    = w_node[LEFT_LSB +: NODE_AW];
  assign w_right   = w_node[RIGHT_LSB +: NODE_AW];
  assign w_cls     = w_node[CLASS_W-1:0];

  // Feature mux; indices past NUM_FEAT select zero
  logic [FEAT_W-1:0] w_fval;

  always_comb begin
    w_fval = '0;
    for (int unsigned i = 0; i < NUM_FEAT; i++) begin
      if (32'(w_fidx) == i) begin
        w_fval = r_feat[i*FEAT_W +: FEAT_W];
      end
    end
  end

  logic [FEAT_W-1:0] w_mask;

`ifdef DTREE_PREC_MASK_EN
  localparam int unsigned PREC_LSB = LEAF_BIT + 1;
  logic [PREC_W-1:0] w_prec;

  assign w_prec = w_node[PREC_LSB +: PREC_W];

  // Keep only the top prec bits; zero or oversized prec compares full width
  always_comb begin
    w_mask = '1;
    if ((w_prec != '0) && (32'(w_prec) <= FEAT_W)) begin
      for (int unsigned b = 0; b < FEAT_W; b++) begin
        w_mask[b] = (b >= (FEAT_W - 32'(w_prec)));
      end
    end
  end
`else
  assign w_mask = '1;
`endif

  logic w_go_left;
  assign w_go_left = (w_fval & w_mask) <= (w_thr & w_mask);

  always_comb begin
    w_state_nxt     = r_state;
    w_feat_nxt      = r_feat;
    w_ptr_nxt       = r_ptr;
    w_steps_nxt     = r_steps;
    w_in_ready_nxt  = r_in_ready;
    w_out_valid_nxt = r_out_valid;
    w_out_class_nxt = r_out_class;
    w_out_err_nxt   = r_out_err;
    w_mem_we        = 1'b0;

    case (r_state)
      IDLE: begin
        w_mem_we = cfg_we && (32'(cfg_addr) < NUM_NODES);
        if (in_valid && r_in_ready) begin
          w_feat_nxt     = in_feat;
          w_ptr_nxt      = '0;
          w_steps_nxt    = '0;
          w_in_ready_nxt = 1'b0;
          w_state_nxt    = WALK;
        end
      end
      WALK: begin
        if (w_is_leaf) begin
          w_out_class_nxt = w_cls;
          w_out_err_nxt   = 1'b0;
          w_out_valid_nxt = 1'b1;
          w_state_nxt     = DONE;
        end else if (r_steps == STEP_W'(MAX_STEPS)) begin
          w_out_class_nxt = '0;
          w_out_err_nxt   = 1'b1;
          w_out_valid_nxt = 1'b1;
          w_state_nxt     = DONE;
        end else begin
          w_ptr_nxt   = w_go_left ? w_left : w_right;
          w_steps_nxt = r_steps + STEP_W'(1);
        end
      end
      DONE: begin
        if (out_ready) begin
          w_out_valid_nxt = 1'b0;
          w_in_ready_nxt  = 1'b1;
          w_state_nxt     = IDLE;
        end
      end
      default: begin
        w_out_valid_nxt = 1'b0;
        w_in_ready_nxt  = 1'b1;
        w_state_nxt     = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_feat      <= '0;
      r_ptr       <= '0;
      r_steps     <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_out_class <= '0;
      r_out_err   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_feat      <= w_feat_nxt;
      r_ptr       <= w_ptr_nxt;
      r_steps     <= w_steps_nxt;
      r_in_ready  <= w_in_ready_nxt;
      r_out_valid <= w_out_valid_nxt;
      r_out_class <= w_out_class_nxt;
      r_out_err   <= w_out_err_nxt;
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_class = r_out_class;
  assign out_err   = r_out_err;

endmodule

// File: tb/tb_dtree_seq_classifier.sv
// Directed scoreboard bench for dtree_seq_classifier (default parameters).
module tb_dtree_seq_classifier;

  localparam int unsigned NUM_FEAT  = 16;
  localparam int unsigned FEAT_W    = 8;
  localparam int unsigned CLASS_W   = 4;
  localparam int unsigned NUM_NODES = 64;
  localparam int unsigned MAX_STEPS = 15;
  localparam int unsigned NODE_AW   = 6;
  localparam int unsigned FIDX_W    = 4;
`ifdef DTREE_PREC_MASK_EN
  localparam int unsigned PREC_W    = 4;
`else
  localparam int unsigned PREC_W    = 0;
`endif
  localparam int unsigned NODE_W    = PREC_W + 1 + FIDX_W + FEAT_W + 2 * NODE_AW + CLASS_W;
  localparam int unsigned FV_W      = NUM_FEAT * FEAT_W;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              in_valid;
  logic              in_ready;
  logic [FV_W-1:0]   in_feat;
  logic              out_valid;
  logic              out_ready;
  logic [CLASS_W-1:0] out_class;
  logic              out_err;
  logic              cfg_we;
  logic [NODE_AW-1:0] cfg_addr;
  logic [NODE_W-1:0] cfg_wdata;

  always #5 clk = ~clk;

  dtree_seq_classifier #(
    .NUM_FEAT (NUM_FEAT),
    .FEAT_W   (FEAT_W),
    .CLASS_W  (CLASS_W),
    .NUM_NODES(NUM_NODES),
    .MAX_STEPS(MAX_STEPS)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_feat  (in_feat),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_class(out_class),
    .out_err  (out_err),
    .cfg_we   (cfg_we),
    .cfg_addr (cfg_addr),
    .cfg_wdata(cfg_wdata)
  );

  typedef struct {
    logic [CLASS_W-1:0] cls;
    logic               err;
    int                 lat;
  } exp_t;

  exp_t sb[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [NODE_W-1:0] mk_node(input logic leaf, input int fidx, input int thr,
                                                input int left, input int right, input int cls);
    logic [NODE_W-1:0] n;
    n = '0;
    n[CLASS_W-1:0]                         = CLASS_W'(cls);
    n[CLASS_W +: NODE_AW]                  = NODE_AW'(right);
    n[CLASS_W+NODE_AW +: NODE_AW]          = NODE_AW'(left);
    n[CLASS_W+2*NODE_AW +: FEAT_W]         = FEAT_W'(thr);
    n[CLASS_W+2*NODE_AW+FEAT_W +: FIDX_W]  = FIDX_W'(fidx);
    n[CLASS_W+2*NODE_AW+FEAT_W+FIDX_W]     = leaf;
    return n;
  endfunction

`ifdef DTREE_PREC_MASK_EN
  function automatic logic [NODE_W-1:0] mk_node_p(input int prec, input int fidx, input int thr,
                                                  input int left, input int right);
    logic [NODE_W-1:0] n;
    n = mk_node(1'b0, fidx, thr, left, right, 0);
    n[NODE_W-1 -: PREC_W] = PREC_W'(prec);
    return n;
  endfunction
`endif

  function automatic logic [FV_W-1:0] feat_with(input int idx, input int val);
    logic [FV_W-1:0] f;
    f = {$urandom, $urandom, $urandom, $urandom};
    f[idx*FEAT_W +: FEAT_W] = FEAT_W'(val);
    return f;
  endfunction

  task automatic write_node(input int addr, input logic [NODE_W-1:0] data);
    @(negedge clk);
    cfg_we    = 1'b1;
    cfg_addr  = NODE_AW'(addr);
    cfg_wdata = data;
    @(negedge clk);
    cfg_we    = 1'b0;
  endtask

  // Drive one accept (optionally with a same-cycle node write) and queue its expectation
  task automatic start_txn(input logic [FV_W-1:0] feat, input int cls, input logic err, input int lat,
                           input bit do_cfg, input int addr, input logic [NODE_W-1:0] data);
    exp_t e;
    @(negedge clk);
    check("in_ready_idle", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_feat  = feat;
    if (do_cfg) begin
      cfg_we    = 1'b1;
      cfg_addr  = NODE_AW'(addr);
      cfg_wdata = data;
    end
    e.cls = CLASS_W'(cls);
    e.err = err;
    e.lat = lat;
    sb.push_back(e);
    @(negedge clk);
    in_valid = 1'b0;
    cfg_we   = 1'b0;
    check("in_ready_busy", 32'(in_ready), 32'd0);
  endtask

  task automatic wait_result(input string tag, input bit consume);
    int   cyc;
    exp_t e;
    cyc = 0;
    while (out_valid !== 1'b1 && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    if (sb.size() == 0) begin
      n_vec++;
      n_miss++;
      $error("FAIL %s_sb: observed=output expected=none queued", tag);
    end else begin
      e = sb.pop_front();
      check({tag, "_lat"}, 32'(cyc), 32'(e.lat));
      check({tag, "_class"}, 32'(out_class), 32'(e.cls));
      check({tag, "_err"}, 32'(out_err), 32'(e.err));
    end
    if (consume) begin
      @(negedge clk);
      check({tag, "_vld_drop"}, 32'(out_valid), 32'd0);
      check({tag, "_rdy_back"}, 32'(in_ready), 32'd1);
    end
  endtask

  logic [NODE_W-1:0] tree0;
  bit                saw_valid;

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_feat   = '0;
    out_ready = 1'b1;
    cfg_we    = 1'b0;
    cfg_addr  = '0;
    cfg_wdata = '0;
    repeat (3) @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_class", 32'(out_class), 32'd0);
    check("rst_out_err", 32'(out_err), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd1);

    // Root leaf
    write_node(0, mk_node(1'b1, 0, 0, 0, 0, 5));
    start_txn(feat_with(0, $urandom_range(255)), 5, 1'b0, 1, 1'b0, 0, '0);
    wait_result("root_leaf", 1'b1);

    // One-level tree around threshold 127 on feature 3
    tree0 = mk_node(1'b0, 3, 127, 1, 2, 0);
    write_node(0, tree0);
    write_node(1, mk_node(1'b1, 0, 0, 0, 0, 7));
    write_node(2, mk_node(1'b1, 0, 0, 0, 0, 9));
    start_txn(feat_with(3, 127), 7, 1'b0, 2, 1'b0, 0, '0);
    wait_result("thr_eq", 1'b1);
    start_txn(feat_with(3, 128), 9, 1'b0, 2, 1'b0, 0, '0);
    wait_result("thr_plus1", 1'b1);
    start_txn(feat_with(3, 0), 7, 1'b0, 2, 1'b0, 0, '0);
    wait_result("thr_min", 1'b1);
    start_txn(feat_with(3, 255), 9, 1'b0, 2, 1'b0, 0, '0);
    wait_result("thr_max", 1'b1);

    // Backpressure hold; writes during DONE must be dropped
    out_ready = 1'b0;
    start_txn(feat_with(3, 100), 7, 1'b0, 2, 1'b0, 0, '0);
    wait_result("hold", 1'b0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      cfg_we    = (k == 0);
      cfg_addr  = NODE_AW'(1);
      cfg_wdata = mk_node(1'b1, 0, 0, 0, 0, 3);
      check("hold_valid", 32'(out_valid), 32'd1);
      check("hold_class", 32'(out_class), 32'd7);
      check("hold_in_ready", 32'(in_ready), 32'd0);
    end
    cfg_we    = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("hold_release_vld", 32'(out_valid), 32'd0);
    check("hold_release_rdy", 32'(in_ready), 32'd1);
    start_txn(feat_with(3, 1), 7, 1'b0, 2, 1'b0, 0, '0);
    wait_result("done_wr_ignored", 1'b1);

    // Reset mid-walk on a self-loop
    write_node(0, mk_node(1'b0, 0, 0, 0, 0, 0));
    start_txn(feat_with(0, 1), 0, 1'b1, 16, 1'b0, 0, '0);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_valid", 32'(out_valid), 32'd0);
    check("midrst_class", 32'(out_class), 32'd0);
    check("midrst_err", 32'(out_err), 32'd0);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    saw_valid = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (out_valid) saw_valid = 1'b1;
    end
    check("midrst_no_pulse", 32'(saw_valid), 32'd0);

    // Step limit on the loop
    start_txn(feat_with(0, 200), 0, 1'b1, 16, 1'b0, 0, '0);
    wait_result("step_limit", 1'b1);

    // Same-cycle write at accept takes effect for the first node read
    start_txn(feat_with(0, 9), 11, 1'b0, 1, 1'b1, 0, mk_node(1'b1, 0, 0, 0, 0, 11));
    wait_result("cfg_at_accept", 1'b1);

    // Two-level path 0 -> 3 -> 4
    write_node(0, mk_node(1'b0, 1, 10, 3, 2, 0));
    write_node(3, mk_node(1'b0, 2, 200, 1, 4, 0));
    write_node(4, mk_node(1'b1, 0, 0, 0, 0, 12));
    start_txn(feat_with(2, 201) & ~(FV_W'(255) << 8) | (FV_W'(5) << 8), 12, 1'b0, 3, 1'b0, 0, '0);
    wait_result("deep_right", 1'b1);
    start_txn(feat_with(2, 200) & ~(FV_W'(255) << 8) | (FV_W'(5) << 8), 7, 1'b0, 3, 1'b0, 0, '0);
    wait_result("deep_left", 1'b1);
    start_txn(feat_with(1, 11), 9, 1'b0, 2, 1'b0, 0, '0);
    wait_result("shallow_right", 1'b1);

`ifdef DTREE_PREC_MASK_EN
    write_node(0, mk_node_p(2, 0, 8'h40, 1, 2));
    start_txn(feat_with(0, 8'h7F), 7, 1'b0, 2, 1'b0, 0, '0);
    wait_result("prec2_7f", 1'b1);
    start_txn(feat_with(0, 8'h80), 9, 1'b0, 2, 1'b0, 0, '0);
    wait_result("prec2_80", 1'b1);
    start_txn(feat_with(0, 8'h41), 7, 1'b0, 2, 1'b0, 0, '0);
    wait_result("prec2_41", 1'b1);
    write_node(0, mk_node_p(8, 0, 8'h40, 1, 2));
    start_txn(feat_with(0, 8'h41), 9, 1'b0, 2, 1'b0, 0, '0);
    wait_result("prec8_41", 1'b1);
    write_node(0, mk_node_p(0, 0, 8'h40, 1, 2));
    start_txn(feat_with(0, 8'h41), 9, 1'b0, 2, 1'b0, 0, '0);
    wait_result("prec0_41", 1'b1);
    start_txn(feat_with(0, 8'h40), 7, 1'b0, 2, 1'b0, 0, '0);
    wait_result("prec0_40", 1'b1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
